// File: rtl/aespim_clmul64_seq.sv
// Sequential 64x64 carry-less multiplier built around one 32x32 CLMUL core.
// Build option: define AESPIM_CLMUL64_KARATSUBA_EN for the 3-multiply Karatsuba schedule; otherwise 4-multiply schoolbook.

module aespim_clmul32_karatsuba (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    function automatic logic [31:0] clmul16(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) acc = acc ^ ({16'b0, x} << i);
        end
        return acc;
    endfunction

    logic [31:0] lo, hi, mm, mid;

    always_comb begin
        lo  = clmul16(a[15:0], b[15:0]);
        hi  = clmul16(a[31:16], b[31:16]);
        mm  = clmul16(a[15:0] ^ a[31:16], b[15:0] ^ b[31:16]);
        mid = mm ^ lo ^ hi;
        p   = {32'b0, lo} ^ {16'b0, mid, 16'b0} ^ {hi, 32'b0};
    end
endmodule

module aespim_clmul64_seq (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [63:0]  a_i,
    input  logic [63:0]  b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] p_o,
    output logic         busy_o
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready_o is high only in IDLE and out_valid_o only in DONE, so the two never overlap.
`ifdef AESPIM_CLMUL64_KARATSUBA_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_DONE} state_t;
`endif

    state_t       state;
    logic [63:0]  a_q, b_q;
    logic [63:0]  p0_q, p2_q;
    logic [127:0] p_q;
    logic         in_ready_q, out_valid_q, busy_q;
    logic [31:0]  mul_a, mul_b;
    logic [63:0]  mul_p;

    function automatic logic [127:0] combine(input logic [63:0] lo, input logic [63:0] mid,
                                             input logic [63:0] hi);
        return {64'b0, lo} ^ {32'b0, mid, 32'b0} ^ {hi, 64'b0};
    endfunction

    always_comb begin
        mul_a = a_q[31:0];
        mul_b = b_q[31:0];
        case (state)
`ifdef AESPIM_CLMUL64_KARATSUBA_EN
            S_MUL1: begin mul_a = a_q[63:32];               mul_b = b_q[63:32];               end
            S_MUL2: begin mul_a = a_q[31:0] ^ a_q[63:32];   mul_b = b_q[31:0] ^ b_q[63:32];   end
`else
            S_MUL1: begin mul_a = a_q[31:0];  mul_b = b_q[63:32]; end
            S_MUL2: begin mul_a = a_q[63:32]; mul_b = b_q[31:0];  end
            S_MUL3: begin mul_a = a_q[63:32]; mul_b = b_q[63:32]; end
`endif
            default: begin mul_a = a_q[31:0]; mul_b = b_q[31:0]; end
        endcase
    end

    aespim_clmul32_karatsuba u_core (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

`ifndef AESPIM_CLMUL64_KARATSUBA_EN
    logic [63:0] pm_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p0_q        <= '0;
            p2_q        <= '0;
`ifndef AESPIM_CLMUL64_KARATSUBA_EN
            pm_q        <= '0;
`endif
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        state      <= S_MUL0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_MUL0: begin
                    p0_q  <= mul_p;
                    state <= S_MUL1;
                end
`ifdef AESPIM_CLMUL64_KARATSUBA_EN
                S_MUL1: begin
                    p2_q  <= mul_p;
                    state <= S_MUL2;
                end
                S_MUL2: begin
                    // The middle product is folded straight into p_q on this edge, so it needs no register of its own.
                    p_q         <= combine(p0_q, mul_p ^ p0_q ^ p2_q, p2_q);
                    state       <= S_DONE;
                    out_valid_q <= 1'b1;
                end
`else
                S_MUL1: begin
                    pm_q  <= mul_p;
                    state <= S_MUL2;
                end
                S_MUL2: begin
                    pm_q  <= pm_q ^ mul_p;
                    state <= S_MUL3;
                end
                S_MUL3: begin
                    p2_q        <= mul_p;
                    p_q         <= combine(p0_q, pm_q, mul_p);
                    state       <= S_DONE;
                    out_valid_q <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (out_ready_i) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign p_o         = p_q;
endmodule
